// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// The PARITY state exists only when FIFO_UART_TX_PARITY_EN is defined.
package fifo_pkg;

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, STOP
  } tx_state_t;
`endif

  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      r_count <= '0;
    else if (clear || r_count == LAST)
      r_count <= '0;
    else
      r_count <= r_count + CW'(1);
  end

  assign tick = (r_count == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream FIFO (8N1, optional even
// parity when FIFO_UART_TX_PARITY_EN is defined).
//
// state  | meaning
// IDLE   | line high, waiting for EN and a non-empty FIFO
// FETCH  | one-cycle FIFO read strobe
// LOAD   | capture FIFO data, restart bit timer
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit (high), BYTE_DONE on its last cycle
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       EN,
  input  logic       FIFO_EMPTY_N,
  input  logic [7:0] FIFO_DATA,
  output logic       FIFO_READ,
  output logic       TX,
  output logic       BUSY,
  output logic       BYTE_DONE
);

  tx_state_t  r_state, w_state_next;
  logic [7:0] r_shift, w_shift_next;
  logic [2:0] r_bit_idx, w_bit_idx_next;
  logic       r_tx, w_tx_next;
  logic       w_tick, w_clear, w_start_ok;
`ifdef FIFO_UART_TX_PARITY_EN
  logic       r_parity;
`endif

  assign w_start_ok = EN && FIFO_EMPTY_N;
  assign w_clear    = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .clear   (w_clear),
    .tick    (w_tick)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (w_start_ok) w_state_next = FETCH;
      FETCH:  w_state_next = LOAD;
      LOAD:   w_state_next = START;
      START:  if (w_tick) w_state_next = DATA;
`ifdef FIFO_UART_TX_PARITY_EN
      DATA:   if (w_tick && r_bit_idx == 3'd7) w_state_next = PARITY;
      PARITY: if (w_tick) w_state_next = STOP;
`else
      DATA:   if (w_tick && r_bit_idx == 3'd7) w_state_next = STOP;
`endif
      STOP:   if (w_tick) w_state_next = w_start_ok ? FETCH : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    if (r_state == LOAD) begin
      w_shift_next   = FIFO_DATA;
      w_bit_idx_next = '0;
    end else if (r_state == DATA && w_tick) begin
      w_shift_next   = {1'b0, r_shift[7:1]};
      w_bit_idx_next = r_bit_idx + 3'd1;
    end
  end

  // TX is computed from the next state so the registered line changes with the state.
  always_comb begin
    w_tx_next = TX_IDLE_LEVEL;
    case (w_state_next)
      START:  w_tx_next = 1'b0;
      DATA:   w_tx_next = w_shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: w_tx_next = r_parity;
`endif
      default: w_tx_next = TX_IDLE_LEVEL;
    endcase
  end

  assign FIFO_READ = (r_state == FETCH);
  assign BUSY      = (r_state != IDLE);
  assign BYTE_DONE = (r_state == STOP) && w_tick;
  assign TX        = r_tx;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= TX_IDLE_LEVEL;
    end else begin
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      r_parity <= 1'b0;
    else if (r_state == LOAD)
      r_parity <= ^FIFO_DATA;
  end
`endif

endmodule
